// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: pops receiver FIFO bytes, parses make/break/E0/Pause
// sequences, filters typematic repeats and presents held-key state to the display.
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_overflow,
  output logic       rx_pop,
  output logic [7:0] scan_code,
  output logic       extended,
  output logic       key_held,
  output logic       key_released,
  output logic [7:0] key_times,
  output logic       make_evt,
  output logic       break_evt,
  output logic       timeout_evt
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t        state, state_next;
  logic [2:0]    skip_cnt, skip_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          do_make, do_break, do_timeout, code_ext, code_match;

  // The FIFO is never popped while reset is held, even though the pop is combinational.
  assign rx_pop       = rx_ready & ~rx_overflow & clrn;
  assign key_released = ~key_held;
  assign code_match   = key_held && ({code_ext, rx_data} == {extended, scan_code});

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      skip_cnt <= '0;
      tcnt     <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      tcnt     <= tcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    tcnt_next  = tcnt;
    do_make    = 1'b0;
    do_break   = 1'b0;
    do_timeout = 1'b0;
    code_ext   = 1'b0;
    if (rx_overflow) begin
      state_next = IDLE;
      skip_next  = '0;
      tcnt_next  = '0;
    end else if (rx_pop) begin
      tcnt_next = '0;
      case (state)
        IDLE: begin
          case (rx_data)
            8'hE0: state_next = EXT;
            8'hF0: state_next = BRK;
            8'hE1: begin
              state_next = SKIP;
              skip_next  = 3'd7;
            end
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_next = IDLE;
            default: do_make = 1'b1;
          endcase
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_next = EXT_BRK;
          end else begin
            state_next = IDLE;
            // E0 12 is the fake-shift prefix some keyboards emit; it is not a key.
            if (rx_data != 8'h12) begin
              do_make  = 1'b1;
              code_ext = 1'b1;
            end
          end
        end
        BRK: begin
          state_next = IDLE;
          do_break   = 1'b1;
        end
        EXT_BRK: begin
          state_next = IDLE;
          do_break   = 1'b1;
          code_ext   = 1'b1;
        end
        SKIP: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_next = IDLE;
            skip_next  = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state == IDLE) begin
      tcnt_next = '0;
    end else if (tcnt == TIMEOUT_LAST) begin
      // This idle cycle brings the count to TIMEOUT_CYCLES-1: abandon the sequence.
      do_timeout = 1'b1;
      state_next = IDLE;
      skip_next  = '0;
      tcnt_next  = '0;
    end else begin
      tcnt_next = tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      scan_code   <= 8'h00;
      extended    <= 1'b0;
      key_held    <= 1'b0;
      key_times   <= 8'h00;
      make_evt    <= 1'b0;
      break_evt   <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      make_evt    <= 1'b0;
      break_evt   <= 1'b0;
      timeout_evt <= do_timeout;
      if (rx_overflow) begin
        key_held <= 1'b0;
      end else if (do_make && !code_match) begin
        scan_code <= rx_data;
        extended  <= code_ext;
        key_held  <= 1'b1;
        key_times <= key_times + 8'd1;
        make_evt  <= 1'b1;
      end else if (do_break && code_match) begin
        key_held  <= 1'b0;
        break_evt <= 1'b1;
      end
    end
  end

endmodule
